// File: rtl/piece_scheduler_pkg.sv
// Shared constants for the piece scheduler: state codes, piece-type width and the "no piece" code.
package piece_scheduler_pkg;
  localparam int TYPE_W    = 3;
  localparam int NUM_TYPES = 7;

  typedef logic [TYPE_W-1:0] piece_t;

  localparam piece_t NONE_CODE = piece_t'(NUM_TYPES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_OVER = 2'd3;

  function automatic logic is_legal(input piece_t c);
    return c != NONE_CODE;
  endfunction
endpackage

// File: rtl/piece_fifo.sv
// Circular preview queue of piece codes; pointers wrap at DEPTH-1 so any DEPTH in 2..7 works.
module piece_fifo
  import piece_scheduler_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_flush,
  input  logic        i_push,
  input  logic        i_pop,
  input  piece_t      i_data,
  output piece_t      o_head,
  output logic [2:0]  o_count,
  output logic        o_full,
  output logic        o_empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  piece_t            r_mem [2**PTR_W];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [2:0]        r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == DEPTH_C);
  assign o_empty = (r_count == 3'd0);
  assign o_count = r_count;
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 3'd0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == LAST_IDX) ? '0 : r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/piece_scheduler.sv
// Session controller: filters random words into piece codes, keeps the preview queue topped up
// and hands out one piece per game-core request.
//   state | meaning
//   IDLE  | waiting for start, queue idle
//   FILL  | filling preview queue after (re)start
//   RUN   | serving requests, refilling whenever not full
//   OVER  | game over, frozen until start
module piece_scheduler
  import piece_scheduler_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int RAND_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_game_over,
  input  logic [RAND_W-1:0] i_rand_in,
  input  logic              i_piece_req,
  output piece_t            o_piece_type,
  output logic              o_piece_valid,
  output piece_t            o_next_type,
  output logic [2:0]        o_queue_count,
  output logic [1:0]        o_state
);
  localparam logic [2:0] LAST_CNT = 3'(DEPTH - 1);

  logic [1:0] r_state;
  logic       r_pending;
  logic       r_retry;
  piece_t     r_last;
  piece_t     r_piece_type;
  logic       r_piece_valid;

  piece_t     w_cand;
  piece_t     w_head;
  logic [2:0] w_count;
  logic       w_full;
  logic       w_empty;
  logic       w_active;
  logic       w_pop;
  logic       w_room;
  logic       w_repeat;
  logic       w_push;
  logic       w_unused_rand;

  assign w_cand        = i_rand_in[TYPE_W-1:0];
  assign w_unused_rand = ^i_rand_in[RAND_W-1:TYPE_W];

  // start and game_over both pre-empt any queue traffic in their cycle.
  assign w_active = (r_state == ST_FILL || r_state == ST_RUN) && !i_start && !i_game_over;
  assign w_pop    = w_active && (r_state == ST_RUN) && (i_piece_req || r_pending) && !w_empty;
  assign w_room   = !w_full || w_pop;
  assign w_repeat = (w_cand == r_last) && !r_retry;
  assign w_push   = w_active && w_room && is_legal(w_cand) && !w_repeat;

  piece_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_start),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_cand),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_pending     <= 1'b0;
      r_retry       <= 1'b0;
      r_last        <= NONE_CODE;
      r_piece_type  <= '0;
      r_piece_valid <= 1'b0;
    end else begin
      r_piece_valid <= w_pop;
      if (w_pop) r_piece_type <= w_head;

      if (i_start) begin
        r_state   <= ST_FILL;
        r_pending <= 1'b0;
        r_retry   <= 1'b0;
        r_last    <= NONE_CODE;
      end else if (i_game_over && (r_state == ST_FILL || r_state == ST_RUN)) begin
        r_state   <= ST_OVER;
        r_pending <= 1'b0;
      end else begin
        case (r_state)
          ST_FILL: begin
            if (i_piece_req) r_pending <= 1'b1;
            if (w_push && w_count == LAST_CNT) r_state <= ST_RUN;
          end
          ST_RUN: begin
            if (w_pop)            r_pending <= 1'b0;
            else if (i_piece_req) r_pending <= 1'b1;
          end
          default: ;
        endcase

        // A repeat is refused only once; the retry flag lets the next repeat through.
        if (w_active && w_room) begin
          if (w_push)                            r_retry <= 1'b0;
          else if (w_repeat && is_legal(w_cand)) r_retry <= 1'b1;
        end
        if (w_push) r_last <= w_cand;
      end
    end
  end

  assign o_piece_type  = r_piece_type;
  assign o_piece_valid = r_piece_valid;
  assign o_next_type   = w_head;
  assign o_queue_count = w_count;
  assign o_state       = r_state;
endmodule

// File: doc/piece_scheduler.md
Name: piece_scheduler

Overview:
- Game-level controller between the 16-bit random-number source and the falling-block game core.
- Sequences a game session: idle, initial fill, run, game over.
- Turns raw random words into legal piece types 0..6 using rejection and anti-repeat rules.
- Keeps a preview queue of upcoming pieces and hands one out per game-core request.

Parameters:
DEPTH, 3, preview queue entries (2..7)
RAND_W, 16, width of random input word
TYPE_W, 3, piece-type code width (7 legal codes, 0..6)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  debounced start/restart, single-cycle pulse
game_over  in  1  game core reports stack overflow, single-cycle pulse
rand_in  in  RAND_W  free-running random word, sampled every cycle
piece_req  in  1  game core requests next piece, single-cycle pulse
piece_type  out  TYPE_W  issued piece code
piece_valid  out  1  one-cycle strobe; piece_type valid this cycle
next_type  out  TYPE_W  queue head (preview); 0 when queue empty
queue_count  out  3  current queue occupancy
state  out  2  0 IDLE, 1 FILL, 2 RUN, 3 OVER

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous, active-high.
- On rst: state=IDLE; queue emptied (count=0, pointers=0); piece_type=0; piece_valid=0; pending=0; last_pushed=7 (none); retry=0.
- Candidate generation:
  - cand = rand_in[2:0].
  - cand==7: reject always.
  - cand==last_pushed and retry==0: reject once and set retry=1.
  - Otherwise accept as long as queue has room. Any accept clears retry.
- Push rule: push occurs when cand is acceptable and (count<DEPTH or a pop happens the same cycle). On a push, last_pushed<=cand.
- IDLE:
  - No pushes; piece_req ignored.
  - start -> FILL. The queue is flushed on entry.
- FILL:
  - Push acceptable candidates each cycle.
  - When count reaches DEPTH -> RUN.
  - piece_req during FILL sets pending.
- RUN:
  - Pops: piece_req with count>0 pops the head. piece_type<=head and piece_valid=1 on the next cycle (latency 1).
  - Refill continues whenever not full.
  - Pop+push in the same cycle with count==DEPTH is legal; count stays DEPTH.
  - piece_req with count==0 sets pending. Pending is served by popping on the first cycle with count>0.
  - Repeated requests while pending are merged; at most one pending.
- Entry into RUN with pending=1: pop on the first RUN cycle.
- OVER:
  - game_over in FILL or RUN -> OVER, same-edge priority over piece_req. No pop that cycle; pending cleared.
  - No pushes; piece_req ignored; piece_valid held 0.
  - start -> FILL, queue flushed, last_pushed=7.
- start in FILL or RUN: restart -> FILL, queue flushed, pending cleared.
- Simultaneous start and game_over: start wins.
- next_type is combinational from the queue head; 0 when count==0.
- Queue is circular. Pointers wrap at DEPTH-1 -> 0, not at a power of two.
- queue_count never exceeds DEPTH and never underflows.

Decomposition:
- Shared package:
  - state encoding constants (IDLE/FILL/RUN/OVER)
  - TYPE_W
  - NUM_TYPES=7
  - NONE code = 7
- One sub-module: piece_fifo.
  - Parameterised by DEPTH.
  - Ports: push/pop, data in/out, count, flush, full/empty.
- The controller holds the FSM, candidate filter, pending flag and output register.

Test Plan:
1. rst held 2 cycles with rand_in=16'h0005 -> state=0, piece_valid=0, queue_count=0, piece_type=0, next_type=0.
2. start pulse; rand_in low bits 7,2,2,2,4 in successive cycles:
   - 7 rejected; first 2 accepted.
   - Second 2 rejected once; third 2 accepted.
   - 4 accepted; queue=2,2,4, state=RUN, next_type=2.
3. In RUN, full queue, piece_req while rand_in low bits=3 -> next cycle piece_valid=1, piece_type=2; queue_count stays 3; tail=3.
4. Five back-to-back piece_req with rand_in low bits held at 7:
   - Three pieces issued, queue_count=0.
   - Remaining requests merge into one pending.
   - Switching rand_in to 1 issues piece 1 one cycle after the push.
5. game_over coincident with piece_req -> state=OVER, no piece_valid; later piece_req ignored; start -> state=FILL, queue_count=0.
6. start and game_over in the same cycle during RUN -> state=FILL, queue flushed; rst mid-FILL -> all outputs return to reset values the next cycle.
